iopmp_err_capture_tlul: RTL
===========================

Name: iopmp_err_capture_tlul

Overview:
- Error-capture and reporting stage directly downstream of the IOPMP per-channel TL-UL request handler.
- Consumes the per-channel violation events produced when a request is denied: address, access type, RRID and matching entry index.
- Arbitrates simultaneous violations round-robin and latches the first one into a locked error record (ERR_REQINFO / ERR_REQADDR / ERR_REQID).
- Counts suppressed violations and drives a level interrupt until software clears the record.

Parameters:
- IOPMPNumChan, 2, number of TL-UL channels feeding violations.
- EntryIdxW, 6, width of the matching-entry index.
- SupCntW, 8, width of the saturating suppressed-violation counter.

Ports:
- clk  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- viol_valid_i  in  [IOPMPNumChan] x 1  one-cycle violation pulse per channel.
- viol_addr_i  in  [IOPMPNumChan] x 34  denied request address.
- viol_access_i  in  [IOPMPNumChan] x iopmp_req_e  access type (read/write).
- viol_rrid_i  in  [IOPMPNumChan] x SourceWidth  requester RRID.
- viol_eid_i  in  [IOPMPNumChan] x EntryIdxW  matching entry index; all-ones means no entry matched.
- ERR_CFG  in  iopmp_pkg::err_cfg  uses .ie (interrupt enable).
- err_clr_i  in  1  write-1-to-clear pulse from the register block.
- err_valid_o  out  1  record holds a captured violation.
- err_ttype_o  out  iopmp_req_e  captured access type.
- err_etype_o  out  err_type_e  captured error type.
- err_addr_o  out  34  captured address.
- err_rrid_o  out  SourceWidth  captured RRID.
- err_eid_o  out  EntryIdxW  captured entry index.
- err_sup_cnt_o  out  SupCntW  number of violations dropped while the record was locked.
- irq_o  out  1  interrupt.

Behaviour:
- Reset (rst_ni low, asynchronous): all outputs 0, FSM in IDLE, RR pointer = 0. Reset mid-capture discards the record.
- FSM states:
  - IDLE: err_valid_o=0.
    - Any viol_valid_i high → grant one channel, latch its fields on that edge, go LOCKED.
    - err_valid_o and all fields are visible the next cycle (latency 1).
  - LOCKED: err_valid_o=1; record frozen.
    - On each cycle with any viol_valid_i high, err_sup_cnt_o += (number of asserted channels).
    - Counter saturates at all-ones and never wraps.
    - err_clr_i → IDLE, counter cleared to 0.
- Arbitration:
  - Round-robin: search starts at the RR pointer, lowest index wins from there.
  - After each grant, the pointer = granted index + 1 modulo IOPMPNumChan.
  - Losing channels in the granting cycle count as suppressed; the counter is 0 + losers on entry to LOCKED.
- err_etype_o:
  - eid all-ones → ERR_NOT_HIT.
  - Otherwise ERR_ILLEGAL_READ or ERR_ILLEGAL_WRITE, chosen by access type.
- Clear and violation in the same cycle while LOCKED: the old record is dropped, the new violation is granted and latched, state stays LOCKED, counter = losers.
- err_clr_i in IDLE: no effect.
- irq_o: registered = err_valid_o && ERR_CFG.ie.
  - Deasserts the cycle after clear.
  - A change of ie takes effect one cycle later.
- Inputs are sampled only while viol_valid_i is high; the other fields are don't-care otherwise.

Decomposition:
- iopmp_pkg: err_type_e (ERR_ILLEGAL_READ=1, ERR_ILLEGAL_WRITE=2, ERR_NOT_HIT=5), err_rec_t (ttype, etype, addr, rrid, eid), err_cap_state_e (IDLE, LOCKED).
- Sub-module iopmp_rr_arbiter (parametric request vector → one-hot grant + index, pointer update on grant) is natural and reusable.

Test Plan:
- Single violation: ch1, addr 0x0_8000_0010, WRITE, rrid 1, eid 3 → next cycle err_valid_o=1, etype ILLEGAL_WRITE, eid 3, sup_cnt 0; with ie=1, irq_o=1 one cycle later.
- Simultaneous violations: ch0 and ch1 both in the same cycle after reset → ch0 record, sup_cnt=1; after clear, both again → ch1 wins (pointer rotated).
- Locked suppression with SupCntW=8: 300 further single-channel violations → sup_cnt_o=255, record unchanged.
- Clear plus new violation in the same cycle: ch0 eid all-ones, READ → record replaced, etype NOT_HIT, err_valid_o stays 1, sup_cnt=0.
- Interrupt gating: ie=0 while locked → irq_o=0; set ie=1 → irq_o=1 after one cycle; clear → irq_o=0 the next cycle.
- Reset mid-operation: rst_ni low while LOCKED → all outputs 0 immediately (asynchronous); first violation after release is captured normally.

Source files
------------

// File: rtl/iopmp_pkg.sv
// Shared types for the IOPMP error-capture stage: access/error encodings,
// the captured error record and the capture FSM states.
package iopmp_pkg;

  localparam int SourceWidth = 8;
  localparam int AddrW       = 34;
  // Record stores the entry index at this width; narrower instances zero-extend.
  localparam int EidMaxW     = 16;

  typedef enum logic {
    IOPMP_READ  = 1'b0,
    IOPMP_WRITE = 1'b1
  } iopmp_req_e;

  typedef enum logic [2:0] {
    ERR_NONE          = 3'd0,
    ERR_ILLEGAL_READ  = 3'd1,
    ERR_ILLEGAL_WRITE = 3'd2,
    ERR_NOT_HIT       = 3'd5
  } err_type_e;

  typedef struct packed {
    logic ie;
  } err_cfg_t;

  typedef struct packed {
    iopmp_req_e             ttype;
    err_type_e              etype;
    logic [AddrW-1:0]       addr;
    logic [SourceWidth-1:0] rrid;
    logic [EidMaxW-1:0]     eid;
  } err_rec_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } err_cap_state_e;

  function automatic err_type_e etype_of(input iopmp_req_e access, input logic no_hit);
    if (no_hit) return ERR_NOT_HIT;
    return (access == IOPMP_WRITE) ? ERR_ILLEGAL_WRITE : ERR_ILLEGAL_READ;
  endfunction

endpackage

// File: rtl/iopmp_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, first requester wins;
// the pointer moves past the winner only when the grant is consumed.
module iopmp_rr_arbiter #(
  parameter  int N    = 2,
  localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_ni,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx,
  output logic            valid
);

  logic [IdxW-1:0] ptr;
  int              cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        idx       = IdxW'(cand);
        gnt[cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= '0;
    end else if (advance && valid) begin
      ptr <= (int'(idx) == N - 1) ? '0 : idx + IdxW'(1);
    end
  end

endmodule

// File: rtl/iopmp_err_capture_tlul.sv
// Captures the first IOPMP violation into a locked error record, counts the
// violations dropped while locked and raises a level interrupt.
module iopmp_err_capture_tlul
  import iopmp_pkg::*;
#(
  parameter int IOPMPNumChan = 2,
  parameter int EntryIdxW    = 6,
  parameter int SupCntW      = 8
) (
  input  logic                   clk,
  input  logic                   rst_ni,
  input  logic [IOPMPNumChan-1:0] viol_valid_i,
  input  logic [AddrW-1:0]       viol_addr_i   [IOPMPNumChan],
  input  iopmp_req_e             viol_access_i [IOPMPNumChan],
  input  logic [SourceWidth-1:0] viol_rrid_i   [IOPMPNumChan],
  input  logic [EntryIdxW-1:0]   viol_eid_i    [IOPMPNumChan],
  input  err_cfg_t               ERR_CFG,
  input  logic                   err_clr_i,
  output logic                   err_valid_o,
  output iopmp_req_e             err_ttype_o,
  output err_type_e              err_etype_o,
  output logic [AddrW-1:0]       err_addr_o,
  output logic [SourceWidth-1:0] err_rrid_o,
  output logic [EntryIdxW-1:0]   err_eid_o,
  output logic [SupCntW-1:0]     err_sup_cnt_o,
  output logic                   irq_o
);

  localparam int IdxW   = (IOPMPNumChan > 1) ? $clog2(IOPMPNumChan) : 1;
  localparam int CntMax = (1 << SupCntW) - 1;

  err_cap_state_e           state_q, state_d;
  err_rec_t                 rec_q, rec_new;
  logic [SupCntW-1:0]       cnt_q;
  logic                     irq_q;
  logic [IOPMPNumChan-1:0]  gnt;
  logic [IdxW-1:0]          gnt_idx;
  logic                     gnt_valid;
  logic                     any_viol;
  logic                     take;
  int                       n_all, n_lose;

  function automatic logic [SupCntW-1:0] sat_add(input logic [SupCntW-1:0] base, input int add);
    int sum;
    sum = int'(base) + add;
    return (sum > CntMax) ? SupCntW'(CntMax) : SupCntW'(sum);
  endfunction

  assign any_viol = |viol_valid_i;
  // A clear in the same cycle as a violation re-arms the record immediately.
  assign take     = any_viol && (state_q == IDLE || err_clr_i);

  iopmp_rr_arbiter #(.N(IOPMPNumChan)) u_arb (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .req     (viol_valid_i),
    .advance (take),
    .gnt     (gnt),
    .idx     (gnt_idx),
    .valid   (gnt_valid)
  );

  always_comb begin
    n_all  = 0;
    n_lose = 0;
    for (int c = 0; c < IOPMPNumChan; c++) begin
      n_all  += int'(viol_valid_i[c]);
      n_lose += int'(viol_valid_i[c] & ~gnt[c]);
    end
  end

  always_comb begin
    rec_new.ttype = viol_access_i[gnt_idx];
    rec_new.etype = etype_of(viol_access_i[gnt_idx], &viol_eid_i[gnt_idx]);
    rec_new.addr  = viol_addr_i[gnt_idx];
    rec_new.rrid  = viol_rrid_i[gnt_idx];
    rec_new.eid   = EidMaxW'(viol_eid_i[gnt_idx]);
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_viol && gnt_valid) state_d = LOCKED;
      LOCKED:  if (err_clr_i && !any_viol) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_valid_o = (state_q == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rec_q <= '0;
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      irq_q <= err_valid_o && ERR_CFG.ie;
      if (take) begin
        rec_q <= rec_new;
        cnt_q <= sat_add('0, n_lose);
      end else if (state_q == LOCKED && err_clr_i) begin
        rec_q <= '0;
        cnt_q <= '0;
      end else if (state_q == LOCKED) begin
        cnt_q <= sat_add(cnt_q, n_all);
      end
    end
  end

  assign err_ttype_o   = rec_q.ttype;
  assign err_etype_o   = rec_q.etype;
  assign err_addr_o    = rec_q.addr;
  assign err_rrid_o    = rec_q.rrid;
  assign err_eid_o     = rec_q.eid[EntryIdxW-1:0];
  assign err_sup_cnt_o = cnt_q;
  assign irq_o         = irq_q;

endmodule
